// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: raster FP16 pixels in, one stride-1 window out per
// accepted pixel once two full rows and two columns of the current frame are buffered.
module conv_window_gen #(
  parameter int IMAGE_SIZE  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [DATA_WIDTH-1:0] ImgP1,
  output logic [DATA_WIDTH-1:0] ImgP2,
  output logic [DATA_WIDTH-1:0] ImgP3,
  output logic [DATA_WIDTH-1:0] ImgP4,
  output logic [DATA_WIDTH-1:0] ImgP5,
  output logic [DATA_WIDTH-1:0] ImgP6,
  output logic [DATA_WIDTH-1:0] ImgP7,
  output logic [DATA_WIDTH-1:0] ImgP8,
  output logic [DATA_WIDTH-1:0] ImgP9,
  output logic [ADDR_SIZE-1:0]  win_row,
  output logic [ADDR_SIZE-1:0]  win_col,
  output logic                  win_last
);

  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(IMAGE_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] TWO  = ADDR_SIZE'(2);
  localparam logic [ADDR_SIZE-1:0] ONE  = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0]  row;
  logic [ADDR_SIZE-1:0]  col;
  logic [DATA_WIDTH-1:0] lb1 [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] lb2 [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] win [TAPS];
  logic                  ready_en;
  logic                  accept;
  logic                  produce;

  // Valid/ready: a pixel moves on in_valid && in_ready, a window on win_valid && win_ready.
  // The single output stage frees up in the same cycle the downstream takes it.
  assign in_ready = ready_en && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready && !clear;
  assign produce  = accept && (row >= TWO) && (col >= TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en  <= 1'b0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      if (clear) begin
        row       <= '0;
        col       <= '0;
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end else begin
        if (accept) begin
          // Shift left one column; new right column is older rows above the new pixel.
          win[0] <= win[1];
          win[1] <= win[2];
          win[2] <= lb2[col];
          win[3] <= win[4];
          win[4] <= win[5];
          win[5] <= lb1[col];
          win[6] <= win[7];
          win[7] <= win[8];
          win[8] <= in_pixel;
          if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + ONE;
          end else begin
            col <= col + ONE;
          end
        end
        if (produce) begin
          win_valid <= 1'b1;
          win_row   <= row - TWO;
          win_col   <= col - TWO;
          win_last  <= (row == LAST) && (col == LAST);
        end else if (win_valid && win_ready) begin
          win_valid <= 1'b0;
          win_last  <= 1'b0;
        end
      end
    end
  end

  // Line buffers hold no reset: rows 0 and 1 of every frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_pixel;
    end
  end

  assign ImgP1 = win[0];
  assign ImgP2 = win[1];
  assign ImgP3 = win[2];
  assign ImgP4 = win[3];
  assign ImgP5 = win[4];
  assign ImgP6 = win[5];
  assign ImgP7 = win[6];
  assign ImgP8 = win[7];
  assign ImgP9 = win[8];

endmodule
